stage4_inst_queue: RTL and testbench

STAGE4_INST_QUEUE -- requirements
Module: stage4_inst_queue

---
 rtl/stage4_inst_queue.sv | 74 +++++++
 tb/tb_stage4_inst_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stage4_inst_queue.sv
// rtl/stage4_inst_queue.sv - decode-to-execute instruction queue
// Circular FWFT buffer of decoded packets with their PCs; hazard unit may stall pops or flush.
module stage4_inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     queue_wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [31:0]              pc_in,
  input  logic                     ren,
  input  logic                     stall_queue,
  input  logic                     flush_queue,
  output logic [WIDTH-1:0]         rdata,
  output logic [31:0]              pc_out,
  output logic                     valid_out,
  output logic                     is_queue_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Status flags come only from registered occupancy, never from this cycle's requests.
  assign valid_out     = (count_q != '0);
  assign is_queue_full = (count_q == FULL_COUNT);
  assign count         = count_q;

  assign rdata  = data_mem[head];
  assign pc_out = pc_mem[head];

  // Fullness is judged before any same-cycle pop, so a full queue never accepts a push.
  assign push_ok   = queue_wen && !is_queue_full && !flush_queue;
  assign pop_ok    = ren && valid_out && !stall_queue && !flush_queue;
  assign push_drop = queue_wen && is_queue_full && !flush_queue && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush_queue) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        data_mem[tail] <= wdata;
        pc_mem[tail]   <= pc_in;
        tail           <= tail + 1'b1;
      end
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: tb/tb_stage4_inst_queue.sv
// tb/tb_stage4_inst_queue.sv - directed scoreboard bench for stage4_inst_queue
// Expected packets are queued when pushes are accepted and compared as pops are accepted.
module tb_stage4_inst_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;

  logic             CLK = 1'b0;
  logic             RST;
  logic             queue_wen;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      pc_in;
  logic             ren;
  logic             stall_queue;
  logic             flush_queue;
  logic [WIDTH-1:0] rdata;
  logic [31:0]      pc_out;
  logic             valid_out;
  logic             is_queue_full;
  logic [$clog2(DEPTH):0] count;
  logic             push_drop;

  typedef struct packed {
    logic [31:0]      pc;
    logic [WIDTH-1:0] data;
  } pkt_t;

  pkt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  stage4_inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .queue_wen     (queue_wen),
    .wdata         (wdata),
    .pc_in         (pc_in),
    .ren           (ren),
    .stall_queue   (stall_queue),
    .flush_queue   (flush_queue),
    .rdata         (rdata),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
    .is_queue_full (is_queue_full),
    .count         (count),
    .push_drop     (push_drop)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input logic wen, input logic [WIDTH-1:0] d, input logic r,
                      input logic st, input logic fl, input logic rs);
    logic  full;
    logic  push;
    logic  pop;
    pkt_t  p;
    p.data      = d;
    p.pc        = 32'h0040_0000 + {d[29:0], 2'b00};
    queue_wen   = wen;
    wdata       = d;
    pc_in       = p.pc;
    ren         = r;
    stall_queue = st;
    flush_queue = fl;
    RST         = rs;
    #1;
    full = (sb.size() == DEPTH);
    push = wen && !full && !fl && !rs;
    pop  = r && (sb.size() > 0) && !st && !fl && !rs;
    check("push_drop", 64'(push_drop), 64'(wen && full && !fl && !rs));
    if (pop) begin
      check("pop_rdata", rdata, sb[0].data);
      check("pop_pc", 64'(pc_out), 64'(sb[0].pc));
      sb.delete(0);
    end
    if (push) sb.push_back(p);
    if (fl || rs) sb.delete();
    @(posedge CLK);
    #1;
    check("count", 64'(count), 64'(sb.size()));
    check("valid_out", 64'(valid_out), 64'(sb.size() > 0));
    check("is_queue_full", 64'(is_queue_full), 64'(sb.size() == DEPTH));
    if (sb.size() > 0) begin
      check("head_rdata", rdata, sb[0].data);
      check("head_pc", 64'(pc_out), 64'(sb[0].pc));
    end
  endtask

  initial begin
    RST = 1'b1; queue_wen = 1'b0; wdata = '0; pc_in = '0;
    ren = 1'b0; stall_queue = 1'b0; flush_queue = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_full", 64'(is_queue_full), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);
    check("rst_push_drop", 64'(push_drop), 64'd0);

    // Fill to full, then overflow push
    for (int i = 0; i < 4; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_full", 64'(is_queue_full), 64'd1);
    step(1'b1, 64'hA4, 1'b0, 1'b0, 1'b0, 1'b0);
    check("overflow_count", 64'(count), 64'd4);
    // Push while full with a pop: push still rejected
    step(1'b1, 64'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drain_valid", 64'(valid_out), 64'd0);

    // Pop on empty with same-cycle push
    step(1'b1, 64'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Interleaved order/wrap with random payloads
    step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_empty", 64'(count), 64'd0);

    // Simultaneous push/pop at count=2
    step(1'b1, 64'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hD2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("simul_count", 64'(count), 64'd2);
    check("simul_head", rdata, 64'hD1);

    // Stall at count=1: pushes continue, head held
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'hE0 + 64'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall_count", 64'(count), 64'd4);
    check("stall_head", rdata, 64'hD2);
    check("stall_full", 64'(is_queue_full), 64'd1);
    step(1'b1, 64'hE3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Flush at count=3 overrides push and pop
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(valid_out), 64'd0);

    // Reset mid-operation at count=3
    for (int i = 0; i < 3; i++) step(1'b1, 64'h90 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(valid_out), 64'd0);
    step(1'b1, 64'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b0_head", rdata, 64'hB0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
